bp_me_mem_cmd_arbiter: RTL and testbench

//  Shares one BedRock stream mem_cmd/mem_resp port between two requesters, e.g. I$ and D$

---
 rtl/bp_me_mem_cmd_arbiter.sv | 147 ++++++++++++++
 tb/tb_bp_me_mem_cmd_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Two-requester BedRock mem_cmd arbiter: round-robin per message, grant held across bursts,
// and a 1-bit order FIFO that steers in-order mem_resp traffic back to the issuing requester.
module bp_me_mem_cmd_arbiter #(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int outstanding_p  = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic [1:0][header_width_p-1:0] req_header_i,
  input  logic [1:0][data_width_p-1:0]   req_data_i,
  input  logic [1:0]                     req_v_i,
  input  logic [1:0]                     req_last_i,
  output logic [1:0]                     req_ready_and_o,

  output logic [header_width_p-1:0]      mem_cmd_header_o,
  output logic [data_width_p-1:0]        mem_cmd_data_o,
  output logic                           mem_cmd_v_o,
  output logic                           mem_cmd_last_o,
  input  logic                           mem_cmd_ready_and_i,

  input  logic [header_width_p-1:0]      mem_resp_header_i,
  input  logic [data_width_p-1:0]        mem_resp_data_i,
  input  logic                           mem_resp_v_i,
  input  logic                           mem_resp_last_i,
  output logic                           mem_resp_ready_and_o,

  output logic [header_width_p-1:0]      resp_header_o,
  output logic [data_width_p-1:0]        resp_data_o,
  output logic                           resp_last_o,
  output logic [1:0]                     resp_v_o,
  input  logic [1:0]                     resp_ready_and_i
);

  localparam int ptr_width_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_width_lp = $clog2(outstanding_p + 1);

  typedef enum logic {e_idle, e_burst} state_e;

  state_e                   state_r;
  logic                     prio_r;
  logic                     lock_r;
  logic [outstanding_p-1:0] order_r;
  logic [ptr_width_lp-1:0]  wptr_r;
  logic [ptr_width_lp-1:0]  rptr_r;
  logic [cnt_width_lp-1:0]  count_r;

  logic fifo_v;
  logic fifo_full;
  logic head;
  logic sel;
  logic grant;
  logic cmd_hs;
  logic push;
  logic pop;

  assign fifo_v    = (count_r != '0);
  assign fifo_full = (count_r == cnt_width_lp'(outstanding_p));
  assign head      = order_r[rptr_r];

  // Priority only breaks ties; a lone valid requester always wins.
  assign sel   = (req_v_i == 2'b11) ? prio_r : req_v_i[1];
  assign grant = (state_r == e_burst) ? lock_r : sel;

  assign mem_cmd_header_o = req_header_i[grant];
  assign mem_cmd_data_o   = req_data_i[grant];
  assign mem_cmd_last_o   = req_last_i[grant];

  always_comb begin
    req_ready_and_o = '0;
    mem_cmd_v_o     = 1'b0;
    if (!reset_i) begin
      if (state_r == e_burst) begin
        req_ready_and_o[lock_r] = mem_cmd_ready_and_i;
        mem_cmd_v_o             = req_v_i[lock_r];
      end else begin
        req_ready_and_o[sel] = mem_cmd_ready_and_i & ~fifo_full;
        mem_cmd_v_o          = req_v_i[sel] & ~fifo_full;
      end
    end
  end

  assign cmd_hs = mem_cmd_v_o & mem_cmd_ready_and_i;
  assign push   = cmd_hs & (state_r == e_idle);

  assign resp_header_o = mem_resp_header_i;
  assign resp_data_o   = mem_resp_data_i;
  assign resp_last_o   = mem_resp_last_i;

  always_comb begin
    resp_v_o = '0;
    if (!reset_i)
      resp_v_o[head] = mem_resp_v_i & fifo_v;
  end

  assign mem_resp_ready_and_o = ~reset_i & fifo_v & resp_ready_and_i[head];
  assign pop = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      prio_r  <= 1'b0;
      lock_r  <= 1'b0;
      order_r <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      unique case (state_r)
        e_idle:
          if (cmd_hs) begin
            if (mem_cmd_last_o) begin
              prio_r <= ~sel;
            end else begin
              lock_r  <= sel;
              state_r <= e_burst;
            end
          end
        e_burst:
          if (cmd_hs && mem_cmd_last_o) begin
            prio_r  <= ~lock_r;
            state_r <= e_idle;
          end
        default: state_r <= e_idle;
      endcase

      if (push) begin
        order_r[wptr_r] <= sel;
        wptr_r <= (wptr_r == ptr_width_lp'(outstanding_p - 1)) ? '0 : wptr_r + ptr_width_lp'(1);
      end
      if (pop)
        rptr_r <= (rptr_r == ptr_width_lp'(outstanding_p - 1)) ? '0 : rptr_r + ptr_width_lp'(1);

      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // A response with nothing outstanding means memory broke the protocol.
  resp_without_cmd_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_resp_v_i && !fifo_v));

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Directed and random self-checking bench for bp_me_mem_cmd_arbiter (default parameters).
module tb_bp_me_mem_cmd_arbiter;

  localparam logic [63:0] H0 = 64'h0000_0000_0000_A000;
  localparam logic [63:0] H1 = 64'h0000_0000_0000_B100;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [1:0][63:0]  req_header_i;
  logic [1:0][63:0]  req_data_i;
  logic [1:0]        req_v_i;
  logic [1:0]        req_last_i;
  logic [1:0]        req_ready_and_o;
  logic [63:0]       mem_cmd_header_o;
  logic [63:0]       mem_cmd_data_o;
  logic              mem_cmd_v_o;
  logic              mem_cmd_last_o;
  logic              mem_cmd_ready_and_i;
  logic [63:0]       mem_resp_header_i;
  logic [63:0]       mem_resp_data_i;
  logic              mem_resp_v_i;
  logic              mem_resp_last_i;
  logic              mem_resp_ready_and_o;
  logic [63:0]       resp_header_o;
  logic [63:0]       resp_data_o;
  logic              resp_last_o;
  logic [1:0]        resp_v_o;
  logic [1:0]        resp_ready_and_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bp_me_mem_cmd_arbiter dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .req_header_i         (req_header_i),
    .req_data_i           (req_data_i),
    .req_v_i              (req_v_i),
    .req_last_i           (req_last_i),
    .req_ready_and_o      (req_ready_and_o),
    .mem_cmd_header_o     (mem_cmd_header_o),
    .mem_cmd_data_o       (mem_cmd_data_o),
    .mem_cmd_v_o          (mem_cmd_v_o),
    .mem_cmd_last_o       (mem_cmd_last_o),
    .mem_cmd_ready_and_i  (mem_cmd_ready_and_i),
    .mem_resp_header_i    (mem_resp_header_i),
    .mem_resp_data_i      (mem_resp_data_i),
    .mem_resp_v_i         (mem_resp_v_i),
    .mem_resp_last_i      (mem_resp_last_i),
    .mem_resp_ready_and_o (mem_resp_ready_and_o),
    .resp_header_o        (resp_header_o),
    .resp_data_o          (resp_data_o),
    .resp_last_o          (resp_last_o),
    .resp_v_o             (resp_v_o),
    .resp_ready_and_i     (resp_ready_and_i)
  );

  task automatic clear_inputs();
    req_header_i        = '{H1, H0};
    req_data_i          = '{64'h1111, 64'h0000};
    req_v_i             = 2'b00;
    req_last_i          = 2'b00;
    mem_cmd_ready_and_i = 1'b0;
    mem_resp_header_i   = '0;
    mem_resp_data_i     = '0;
    mem_resp_v_i        = 1'b0;
    mem_resp_last_i     = 1'b0;
    resp_ready_and_i    = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clear_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    clear_inputs();
    reset_i = 1'b1;
    req_v_i = 2'b11;
    req_last_i = 2'b11;
    mem_cmd_ready_and_i = 1'b1;
    resp_ready_and_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({req_ready_and_o, mem_cmd_v_o, resp_v_o, mem_resp_ready_and_o} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got rdy=%b cmd_v=%b resp_v=%b mresp_rdy=%b required all 0",
                 req_ready_and_o, mem_cmd_v_o, resp_v_o, mem_resp_ready_and_o);
      end
      @(negedge clk_i);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (req_ready_and_o !== 2'b01 || mem_cmd_v_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release: got rdy=%b cmd_v=%b required rdy=01 cmd_v=1",
               req_ready_and_o, mem_cmd_v_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      req_v_i = 2'b11;
      req_last_i = 2'b11;
      mem_cmd_ready_and_i = 1'b1;
      #1;
      checks++;
      if (req_ready_and_o !== exp_rdy[i] || mem_cmd_v_o !== 1'b1 ||
          mem_cmd_header_o !== ((exp_rdy[i] == 2'b01) ? H0 : H1)) begin
        failures++;
        $display("[TB] FAIL rr_grant%0d: got rdy=%b v=%b hdr=%h required rdy=%b v=1",
                 i, req_ready_and_o, mem_cmd_v_o, mem_cmd_header_o, exp_rdy[i]);
      end
    end
    @(negedge clk_i);
    req_v_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      mem_resp_v_i = 1'b1;
      mem_resp_last_i = 1'b1;
      mem_resp_header_i = 64'(i);
      resp_ready_and_i = 2'b11;
      #1;
      checks++;
      if (resp_v_o !== exp_rdy[i] || mem_resp_ready_and_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rr_order%0d: got resp_v=%b ready=%b required resp_v=%b ready=1",
                 i, resp_v_o, mem_resp_ready_and_o, exp_rdy[i]);
      end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_burst_lock();
    logic [1:0] v_tab [7];
    logic       l0_tab [7];
    logic [1:0] exp_rdy [7];
    logic       exp_v [7];
    v_tab   = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    l0_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    exp_v   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      req_v_i = v_tab[i];
      req_last_i = {1'b1, l0_tab[i]};
      req_data_i = '{64'hD1_0000 + 64'(i), 64'hD0_0000 + 64'(i)};
      mem_cmd_ready_and_i = 1'b1;
      #1;
      checks++;
      if (req_ready_and_o !== exp_rdy[i] || mem_cmd_v_o !== exp_v[i] ||
          mem_cmd_header_o !== ((exp_rdy[i] == 2'b10) ? H1 : H0) ||
          mem_cmd_data_o !== ((exp_rdy[i] == 2'b10) ? 64'hD1_0000 + 64'(i) : 64'hD0_0000 + 64'(i)) ||
          mem_cmd_last_o !== ((exp_rdy[i] == 2'b10) ? 1'b1 : l0_tab[i])) begin
        failures++;
        $display("[TB] FAIL burst_cyc%0d: got rdy=%b v=%b hdr=%h data=%h last=%b required rdy=%b v=%b",
                 i, req_ready_and_o, mem_cmd_v_o, mem_cmd_header_o, mem_cmd_data_o,
                 mem_cmd_last_o, exp_rdy[i], exp_v[i]);
      end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      req_v_i = 2'b01;
      req_last_i = 2'b11;
      mem_cmd_ready_and_i = 1'b1;
      if (i == 6) begin
        mem_resp_v_i = 1'b1;
        mem_resp_last_i = 1'b1;
        resp_ready_and_i = 2'b11;
      end
      #1;
      checks++;
      if (mem_cmd_v_o !== (i < 4) || req_ready_and_o !== ((i < 4) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("[TB] FAIL full_cyc%0d: got cmd_v=%b rdy=%b required cmd_v=%b",
                 i, mem_cmd_v_o, req_ready_and_o, (i < 4));
      end
      if (i == 6) begin
        checks++;
        if (resp_v_o !== 2'b01 || mem_resp_ready_and_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL full_pop: got resp_v=%b ready=%b required 01 1",
                   resp_v_o, mem_resp_ready_and_o);
        end
      end
    end
    @(negedge clk_i);
    mem_resp_v_i = 1'b0;
    mem_resp_last_i = 1'b0;
    #1;
    checks++;
    if (mem_cmd_v_o !== 1'b1 || req_ready_and_o !== 2'b01) begin
      failures++;
      $display("[TB] FAIL full_release: got cmd_v=%b rdy=%b required 1 01",
               mem_cmd_v_o, req_ready_and_o);
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_resp_routing();
    logic [1:0] order_tab [3];
    logic [1:0] exp_rv [6];
    order_tab = '{2'b10, 2'b01, 2'b01};
    exp_rv = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      req_v_i = order_tab[i];
      req_last_i = 2'b11;
      mem_cmd_ready_and_i = 1'b1;
    end
    @(negedge clk_i);
    req_v_i = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      mem_resp_v_i = 1'b1;
      mem_resp_last_i = (i % 2 == 1);
      mem_resp_data_i = 64'hC0DE_0000 + 64'(i);
      resp_ready_and_i = 2'b11;
      #1;
      checks++;
      if (resp_v_o !== exp_rv[i] || resp_last_o !== (i % 2 == 1) ||
          resp_data_o !== 64'hC0DE_0000 + 64'(i) || mem_resp_ready_and_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL route_beat%0d: got resp_v=%b last=%b data=%h ready=%b required resp_v=%b",
                 i, resp_v_o, resp_last_o, resp_data_o, mem_resp_ready_and_o, exp_rv[i]);
      end
    end
    @(negedge clk_i);
    mem_resp_v_i = 1'b0;
    mem_resp_last_i = 1'b0;
    #1;
    checks++;
    if (mem_resp_ready_and_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL route_empty: got ready=%b required 0", mem_resp_ready_and_o);
    end
    clear_inputs();
  endtask

  task automatic test_resp_backpressure();
    do_reset();
    @(negedge clk_i);
    req_v_i = 2'b10;
    req_last_i = 2'b11;
    mem_cmd_ready_and_i = 1'b1;
    @(negedge clk_i);
    req_v_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_resp_v_i = 1'b1;
      mem_resp_last_i = 1'b1;
      resp_ready_and_i = (i < 2) ? 2'b01 : 2'b11;
      #1;
      checks++;
      if (resp_v_o !== 2'b10 || mem_resp_ready_and_o !== (i == 2)) begin
        failures++;
        $display("[TB] FAIL bp_cyc%0d: got resp_v=%b ready=%b required resp_v=10 ready=%b",
                 i, resp_v_o, mem_resp_ready_and_o, (i == 2));
      end
    end
    @(negedge clk_i);
    mem_resp_v_i = 1'b0;
    #1;
    checks++;
    if (mem_resp_ready_and_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_popped: got ready=%b required 0", mem_resp_ready_and_o);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk_i);
    req_v_i = 2'b01;
    req_last_i = 2'b00;
    mem_cmd_ready_and_i = 1'b1;
    resp_ready_and_i = 2'b11;
    #1;
    checks++;
    if (req_ready_and_o !== 2'b01) begin
      failures++;
      $display("[TB] FAIL mid_first: got rdy=%b required 01", req_ready_and_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    checks++;
    if ({req_ready_and_o, mem_cmd_v_o, resp_v_o, mem_resp_ready_and_o} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: got rdy=%b cmd_v=%b resp_v=%b mresp_rdy=%b required all 0",
               req_ready_and_o, mem_cmd_v_o, resp_v_o, mem_resp_ready_and_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    req_v_i = 2'b10;
    req_last_i = 2'b11;
    #1;
    checks++;
    if (req_ready_and_o !== 2'b10 || mem_cmd_v_o !== 1'b1 || mem_resp_ready_and_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_after: got rdy=%b cmd_v=%b mresp_rdy=%b required 10 1 0",
               req_ready_and_o, mem_cmd_v_o, mem_resp_ready_and_o);
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_random();
    logic [63:0] mem_q [$];
    logic [63:0] cur_hdr [2];
    int          tx_seq [2];
    int          rx_seq [2];
    int          len [2];
    int          beat [2];
    bit          sending [2];
    int          rbeat;
    int          id;
    int          xfers;
    bit          stop;
    bit          drained;
    drained = 1'b0;
    rbeat = 0;
    for (int r = 0; r < 2; r++) begin
      tx_seq[r] = 0; rx_seq[r] = 0; len[r] = 0; beat[r] = 0; sending[r] = 1'b0; cur_hdr[r] = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stop = (cyc >= 500);
      if (stop && !sending[0] && !sending[1] && mem_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk_i);
      for (int r = 0; r < 2; r++) begin
        if (!sending[r] && !stop && $urandom_range(0, 2) == 0) begin
          sending[r] = 1'b1;
          len[r] = $urandom_range(1, 3);
          beat[r] = 0;
          cur_hdr[r] = {40'h5A, 7'h0, 1'(r), 8'(tx_seq[r])};
        end
        req_v_i[r] = sending[r];
        req_last_i[r] = sending[r] && (beat[r] == len[r] - 1);
        req_header_i[r] = cur_hdr[r];
        req_data_i[r] = {$urandom, $urandom};
      end
      mem_cmd_ready_and_i = ($urandom_range(0, 3) != 0);
      if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_resp_v_i = 1'b1;
        mem_resp_header_i = mem_q[0];
        mem_resp_data_i = {$urandom, $urandom};
        mem_resp_last_i = (rbeat == int'(mem_q[0][0]));
      end else begin
        mem_resp_v_i = 1'b0;
        mem_resp_last_i = 1'b0;
      end
      resp_ready_and_i = 2'($urandom_range(0, 3));
      #1;
      xfers = 0;
      for (int r = 0; r < 2; r++) begin
        if (req_v_i[r] && req_ready_and_o[r]) begin
          xfers++;
          checks++;
          if (mem_cmd_header_o !== cur_hdr[r] || mem_cmd_data_o !== req_data_i[r] ||
              mem_cmd_last_o !== req_last_i[r]) begin
            failures++;
            $display("[TB] FAIL rnd_cmd_mux: got hdr=%h data=%h last=%b required hdr=%h data=%h last=%b",
                     mem_cmd_header_o, mem_cmd_data_o, mem_cmd_last_o,
                     cur_hdr[r], req_data_i[r], req_last_i[r]);
          end
          if (beat[r] == 0) mem_q.push_back(cur_hdr[r]);
          beat[r]++;
          if (req_last_i[r]) begin
            sending[r] = 1'b0;
            tx_seq[r]++;
          end
        end
      end
      checks++;
      if ((mem_cmd_v_o && mem_cmd_ready_and_i) !== (xfers == 1) || xfers > 1) begin
        failures++;
        $display("[TB] FAIL rnd_cmd_hs: got mem_hs=%b required %0d requester beats",
                 mem_cmd_v_o && mem_cmd_ready_and_i, xfers);
      end
      if (mem_resp_v_i) begin
        id = int'(mem_q[0][8]);
        checks++;
        if (resp_v_o !== (2'b01 << id) || mem_resp_ready_and_o !== resp_ready_and_i[id] ||
            resp_header_o !== mem_q[0]) begin
          failures++;
          $display("[TB] FAIL rnd_resp_route: got resp_v=%b ready=%b hdr=%h required resp_v=%b ready=%b hdr=%h",
                   resp_v_o, mem_resp_ready_and_o, resp_header_o, 2'b01 << id,
                   resp_ready_and_i[id], mem_q[0]);
        end
        if (resp_ready_and_i[id]) begin
          checks++;
          if (mem_q[0][7:0] !== 8'(rx_seq[id])) begin
            failures++;
            $display("[TB] FAIL rnd_resp_order: got seq=%0d required %0d for requester %0d",
                     mem_q[0][7:0], 8'(rx_seq[id]), id);
          end
          if (mem_resp_last_i) begin
            void'(mem_q.pop_front());
            rx_seq[id]++;
            rbeat = 0;
          end else begin
            rbeat++;
          end
        end
      end
    end
    checks++;
    if (!drained || rx_seq[0] != tx_seq[0] || rx_seq[1] != tx_seq[1]) begin
      failures++;
      $display("[TB] FAIL rnd_drain: got drained=%b rx=%0d/%0d required drained=1 rx=%0d/%0d",
               drained, rx_seq[0], rx_seq[1], tx_seq[0], tx_seq[1]);
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  initial begin
    reset_i = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_fifo_full();
    test_resp_routing();
    test_resp_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
